// File: rtl/div_param_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_param_pkg;

    // Encoding 2'b11 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10
    } div_state_e;

    // Width of the iteration counter for a W-bit divide (W >= 2).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_param_paso.sv
// One combinational restoring-division step: shift in a dividend bit, then
// subtract the divisor if it fits.
module div_param_paso #(
    parameter int unsigned W = 4
) (
    input  logic [W:0] rem,
    input  logic       bit_in,
    input  logic [W:0] divisor,
    output logic [W:0] rem_next,
    output logic       q_bit
);

    logic [W:0] shifted;
    // The partial remainder is always below the divisor, so its top bit is zero.
    logic       unused_rem_msb;

    assign unused_rem_msb = rem[W];

    // Shift-and-compare step; W+1 bits keep the shifted remainder from wrapping.
    always_comb begin
        shifted  = {rem[W-1:0], bit_in};
        q_bit    = (shifted >= divisor);
        rem_next = q_bit ? (shifted - divisor) : shifted;
    end

endmodule

// File: rtl/div_param.sv
// Parametrised multi-cycle restoring divider with an edge-triggered start,
// divide-by-zero and signed-overflow flags.
module div_param
    import div_param_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] numerador,
    input  logic [W-1:0] denominador,
    output logic [W-1:0] cociente,
    output logic [W-1:0] resto,
    output logic         busy,
    output logic         finish,
    output logic         div_cero,
    output logic         desborde
);

    localparam int unsigned    CntW   = cnt_width(W);
    localparam logic [W-1:0]   MinVal = {1'b1, {(W-1){1'b0}}};
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    div_state_e state_q, state_d;
    logic            start_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W:0]      dsr_q, dsr_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    coc_q, coc_d;
    logic [W-1:0]    res_q, res_d;
    logic            fin_q, fin_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;

    logic            launch;
    logic            num_neg, den_neg;
    logic [W-1:0]    num_abs, den_abs;
    logic            ovf_case;
    logic [W:0]      step_rem;
    logic            step_q;

    div_param_paso #(
        .W (W)
    ) u_paso (
        .rem      (rem_q),
        .bit_in   (dvd_q[W-1]),
        .divisor  (dsr_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Launch decode and operand magnitude/sign extraction.
    always_comb begin
        launch   = (state_q == StIdle) && start && !start_q;
        num_neg  = SIGNED && numerador[W-1];
        den_neg  = SIGNED && denominador[W-1];
        num_abs  = num_neg ? (W'(0) - numerador) : numerador;
        den_abs  = den_neg ? (W'(0) - denominador) : denominador;
        ovf_case = SIGNED && (numerador == MinVal) && (denominador == '1);
    end

    // Next-state and datapath update for the IDLE/CALC/FIX sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        coc_d     = coc_q;
        res_d     = res_q;
        fin_d     = fin_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    fin_d     = 1'b0;
                    dz_d      = 1'b0;
                    ovf_d     = 1'b0;
                    dvd_d     = num_abs;
                    dsr_d     = {1'b0, den_abs};
                    neg_quo_d = num_neg ^ den_neg;
                    neg_rem_d = num_neg;
                    if (denominador == '0) begin
                        // Divide-by-zero resolves in the launch cycle.
                        coc_d = '1;
                        res_d = numerador;
                        dz_d  = 1'b1;
                        fin_d = 1'b1;
                    end else if (ovf_case) begin
                        coc_d = MinVal;
                        res_d = '0;
                        ovf_d = 1'b1;
                        fin_d = 1'b1;
                    end else begin
                        state_d = StCalc;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = '0;
                    end
                end
            end
            StCalc: begin
                rem_d = step_rem;
                quo_d = {quo_q[W-2:0], step_q};
                dvd_d = {dvd_q[W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                coc_d   = neg_quo_q ? (W'(0) - quo_q) : quo_q;
                res_d   = neg_rem_q ? (W'(0) - rem_q[W-1:0]) : rem_q[W-1:0];
                fin_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            coc_q     <= '0;
            res_q     <= '0;
            fin_q     <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            coc_q     <= coc_d;
            res_q     <= res_d;
            fin_q     <= fin_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    // Output drive straight from registers.
    always_comb begin
        cociente = coc_q;
        resto    = res_q;
        busy     = (state_q == StCalc);
        finish   = fin_q;
        div_cero = dz_q;
        desborde = ovf_q;
    end

endmodule

// File: tb/tb_div_param.sv
// Directed bench for div_param: one unsigned and one signed W=4 instance.
module tb_div_param;

    logic       clk;
    logic       rst;
    logic       u_start, s_start;
    logic [3:0] u_num, u_den, s_num, s_den;
    logic [3:0] u_coc, u_res, s_coc, s_res;
    logic       u_busy, u_fin, u_dz, u_ovf;
    logic       s_busy, s_fin, s_dz, s_ovf;

    int checks = 0;
    int errors = 0;

    div_param #(.W(4), .SIGNED(1'b0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (u_start),
        .numerador   (u_num),
        .denominador (u_den),
        .cociente    (u_coc),
        .resto       (u_res),
        .busy        (u_busy),
        .finish      (u_fin),
        .div_cero    (u_dz),
        .desborde    (u_ovf)
    );

    div_param #(.W(4), .SIGNED(1'b1)) s_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (s_start),
        .numerador   (s_num),
        .denominador (s_den),
        .cociente    (s_coc),
        .resto       (s_res),
        .busy        (s_busy),
        .finish      (s_fin),
        .div_cero    (s_dz),
        .desborde    (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_start = 1'b0; s_start = 1'b0;
        u_num = 4'd0; u_den = 4'd0; s_num = 4'd0; s_den = 4'd0;
        tick(2);
        rst = 1'b0;
        checks++;
        if ({u_coc, u_res, u_busy, u_fin, u_dz, u_ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_u: got %h required 000", {u_coc, u_res, u_busy, u_fin, u_dz, u_ovf});
        end
        checks++;
        if ({s_coc, s_res, s_busy, s_fin, s_dz, s_ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_s: got %h required 000", {s_coc, s_res, s_busy, s_fin, s_dz, s_ovf});
        end
    endtask

    task automatic test_basic_8_2();
        u_num = 4'd8; u_den = 4'd2; u_start = 1'b1;
        tick(1);
        u_start = 1'b0;
        checks++;
        if (u_busy !== 1'b1 || u_fin !== 1'b0) begin
            errors++;
            $display("FAIL basic_launch: busy=%b finish=%b required 1 0", u_busy, u_fin);
        end
        tick(4);
        checks++;
        if (u_fin !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_finish: finish=%b required 0", u_fin);
        end
        tick(1);
        checks++;
        if ({u_fin, u_busy, u_dz, u_coc, u_res} !== {3'b100, 4'b0100, 4'b0000}) begin
            errors++;
            $display("FAIL basic_8_2: fin=%b busy=%b dz=%b q=%b r=%b required 1 0 0 0100 0000",
                     u_fin, u_busy, u_dz, u_coc, u_res);
        end
    endtask

    task automatic test_busy_15_4();
        int  nbusy = 0;
        bit  done  = 0;
        u_num = 4'd15; u_den = 4'd4; u_start = 1'b1;
        tick(1);
        u_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (u_busy) nbusy++;
            if (u_fin) begin
                done = 1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL busy_15_4_timeout: finish never rose within 20 cycles");
        end
        checks++;
        if (nbusy != 4) begin
            errors++;
            $display("FAIL busy_15_4_cycles: got %0d required 4", nbusy);
        end
        checks++;
        if (u_coc !== 4'b0011 || u_res !== 4'b0011) begin
            errors++;
            $display("FAIL div_15_4: q=%b r=%b required 0011 0011", u_coc, u_res);
        end
    endtask

    task automatic test_div_zero();
        bit seen_busy = 0;
        u_num = 4'd8; u_den = 4'd0; u_start = 1'b1;
        tick(1);
        u_start = 1'b0;
        if (u_busy) seen_busy = 1;
        checks++;
        if ({u_fin, u_dz, u_ovf, u_coc, u_res} !== {3'b110, 4'b1111, 4'b1000}) begin
            errors++;
            $display("FAIL div_zero: fin=%b dz=%b ovf=%b q=%b r=%b required 1 1 0 1111 1000",
                     u_fin, u_dz, u_ovf, u_coc, u_res);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (u_busy) seen_busy = 1;
        end
        checks++;
        if (seen_busy) begin
            errors++;
            $display("FAIL div_zero_busy: busy seen 1 required never");
        end
    endtask

    task automatic test_signed();
        // -7 / 2 -> -3 rem -1
        s_num = 4'b1001; s_den = 4'b0010; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        tick(5);
        checks++;
        if ({s_fin, s_ovf, s_coc, s_res} !== {2'b10, 4'b1101, 4'b1111}) begin
            errors++;
            $display("FAIL signed_m7_2: fin=%b ovf=%b q=%b r=%b required 1 0 1101 1111",
                     s_fin, s_ovf, s_coc, s_res);
        end
        // 7 / -2 -> -3 rem 1
        s_num = 4'b0111; s_den = 4'b1110; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        tick(5);
        checks++;
        if ({s_fin, s_coc, s_res} !== {1'b1, 4'b1101, 4'b0001}) begin
            errors++;
            $display("FAIL signed_7_m2: fin=%b q=%b r=%b required 1 1101 0001", s_fin, s_coc, s_res);
        end
        // -8 / -1 overflows
        s_num = 4'b1000; s_den = 4'b1111; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        checks++;
        if ({s_fin, s_ovf, s_dz, s_busy, s_coc, s_res} !== {4'b1100, 4'b1000, 4'b0000}) begin
            errors++;
            $display("FAIL signed_overflow: fin=%b ovf=%b dz=%b busy=%b q=%b r=%b required 1 1 0 0 1000 0000",
                     s_fin, s_ovf, s_dz, s_busy, s_coc, s_res);
        end
    endtask

    task automatic test_held_start();
        int nbusy = 0;
        int nrise = 0;
        bit prev_fin;
        u_num = 4'd9; u_den = 4'd2; u_start = 1'b1;
        prev_fin = u_fin;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (i == 1) begin
                u_num = 4'd15; u_den = 4'd1;
            end
            if (u_busy) nbusy++;
            if (u_fin && !prev_fin) nrise++;
            prev_fin = u_fin;
        end
        checks++;
        if (nbusy != 4 || nrise != 1) begin
            errors++;
            $display("FAIL held_start_once: busy cycles=%0d finish rises=%0d required 4 1", nbusy, nrise);
        end
        checks++;
        if (u_coc !== 4'd4 || u_res !== 4'd1) begin
            errors++;
            $display("FAIL held_start_result: q=%0d r=%0d required 4 1", u_coc, u_res);
        end
        u_start = 1'b0;
        tick(1);
    endtask

    task automatic test_rst_mid();
        u_num = 4'd13; u_den = 4'd3; u_start = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({u_coc, u_res, u_busy, u_fin, u_dz, u_ovf} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_abort: got %h required 000", {u_coc, u_res, u_busy, u_fin, u_dz, u_ovf});
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (u_busy !== 1'b1) begin
            errord_msg();
        end
        tick(5);
        checks++;
        if ({u_fin, u_coc, u_res} !== {1'b1, 4'd4, 4'd1}) begin
            errors++;
            $display("FAIL rst_mid_rerun: fin=%b q=%0d r=%0d required 1 4 1", u_fin, u_coc, u_res);
        end
        u_start = 1'b0;
        tick(1);
    endtask

    task automatic errord_msg();
        errors++;
        $display("FAIL rst_release_launch: busy=%b required 1", u_busy);
    endtask

    task automatic test_back_to_back();
        // finish is 1 here; a new launch must clear it at the launch edge.
        u_num = 4'd6; u_den = 4'd4; u_start = 1'b1;
        tick(1);
        u_start = 1'b0;
        checks++;
        if (u_fin !== 1'b0 || u_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_launch: finish=%b busy=%b required 0 1", u_fin, u_busy);
        end
        tick(5);
        checks++;
        if ({u_fin, u_coc, u_res} !== {1'b1, 4'd1, 4'd2}) begin
            errors++;
            $display("FAIL b2b_result: fin=%b q=%0d r=%0d required 1 1 2", u_fin, u_coc, u_res);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8_2();
        test_busy_15_4();
        test_div_zero();
        test_signed();
        test_held_start();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
